// File: rtl/light_package.sv
// Shared types for the N-phase traffic light controller.
//   colors      : per-phase lamp colour driven to the lamp drivers
//   tlc_state_t : controller state (green / yellow / all-red)
//   max4        : helper used to size the shared timing counters
package light_package;

   typedef enum logic [1:0] {
      red    = 2'd0,
      yellow = 2'd1,
      green  = 2'd2
   } colors;

   typedef enum logic [1:0] {
      TLC_GREEN  = 2'd0,
      TLC_YELLOW = 2'd1,
      TLC_ALLRED = 2'd2
   } tlc_state_t;

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin next-phase selector (combinational).
//   req_i   : per-phase demand
//   cur_i   : current / last-served phase
//   nxt_o   : first requesting phase in order cur+1, cur+2, ... wrapping, cur last
//   valid_o : any demand present
module tlc_rr_pick
   import light_package::*;
#(
   parameter  int unsigned NUM_PHASES = 5,
   localparam int unsigned PW         = $clog2(NUM_PHASES)
) (
   input  logic [NUM_PHASES-1:0] req_i,
   input  logic [PW-1:0]         cur_i,
   output logic [PW-1:0]         nxt_o,
   output logic                  valid_o
);

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] c, input int unsigned k);
      int unsigned s;
      s = 32'(c) + k;
      if (s >= NUM_PHASES) s = s - NUM_PHASES;
      return PW'(s);
   endfunction

   // Scan farthest offset first so the nearest requester after cur wins.
   always_comb begin
      nxt_o   = cur_i;
      valid_o = |req_i;
      for (int unsigned k = NUM_PHASES; k > 0; k--) begin
         if (req_i[wrap_add(cur_i, k)]) nxt_o = wrap_add(cur_i, k);
      end
   end

endmodule

// File: rtl/tlc_nphase.sv
// N-phase traffic light controller: one phase green at a time, yellow then
// all-red between phases, round-robin selection among demanding phases.
//   clk, reset     : clock and asynchronous active-high reset
//   req            : per-phase demand (synchronous to clk)
//   preempt        : (TLC_PREEMPT_EN only) force service of preempt_phase
//   preempt_phase  : (TLC_PREEMPT_EN only) phase to serve under preempt
//   light          : per-phase lamp colour
//   phase          : current or last-served phase
//   all_red        : high in the all-red state
// Optional feature macro: TLC_PREEMPT_EN.
module tlc_nphase
   import light_package::*;
#(
   parameter  int unsigned NUM_PHASES = 5,
   parameter  int unsigned YELLOW_CYC = 2,
   parameter  int unsigned ALLRED_CYC = 1,
   parameter  int unsigned GAP_CYC    = 4,
   parameter  int unsigned MAX_CYC    = 9,
   localparam int unsigned PW         = $clog2(NUM_PHASES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_PHASES-1:0] req,
`ifdef TLC_PREEMPT_EN
   input  logic                  preempt,
   input  logic [PW-1:0]         preempt_phase,
`endif
   output colors                 light [NUM_PHASES],
   output logic [PW-1:0]         phase,
   output logic                  all_red
);

   localparam int unsigned CW = $clog2(max4(YELLOW_CYC, ALLRED_CYC, GAP_CYC, MAX_CYC)) + 1;
   localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_CYC - 1);
   localparam logic [CW-1:0] AR_LAST  = CW'(ALLRED_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] MAX_LAST = CW'(MAX_CYC - 1);

   tlc_state_t      state_q, state_d;
   logic [PW-1:0]   cur_q, cur_d;
   logic [CW-1:0]   gap_q, gap_d;
   logic [CW-1:0]   max_q, max_d;
   logic [CW-1:0]   tmr_q, tmr_d;

   logic            own_c, other_c, timeout_c;
   logic [PW-1:0]   rr_nxt_c;
   logic            rr_valid_c;
   logic            pre_yield_c, pre_hold_c, pre_take_c;
   logic [PW-1:0]   pre_target_c;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] lim);
      return (v == lim) ? v : v + CW'(1);
   endfunction

   assign own_c   = req[cur_q];
   assign other_c = |(req & ~(NUM_PHASES'(1) << cur_q));

`ifdef TLC_PREEMPT_EN
   // Preempt of another phase yields now; preempt of the served phase freezes it green.
   assign pre_yield_c  = preempt && (cur_q != preempt_phase);
   assign pre_hold_c   = preempt && (cur_q == preempt_phase);
   assign pre_take_c   = preempt;
   assign pre_target_c = preempt_phase;
`else
   assign pre_yield_c  = 1'b0;
   assign pre_hold_c   = 1'b0;
   assign pre_take_c   = 1'b0;
   assign pre_target_c = '0;
`endif

   tlc_rr_pick #(.NUM_PHASES(NUM_PHASES)) u_rr_pick (
      .req_i   (req),
      .cur_i   (cur_q),
      .nxt_o   (rr_nxt_c),
      .valid_o (rr_valid_c)
   );

   // State register, phase register and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= TLC_ALLRED;
         cur_q   <= PW'(NUM_PHASES - 1);
         gap_q   <= '0;
         max_q   <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         gap_q   <= gap_d;
         max_q   <= max_d;
         tmr_q   <= tmr_d;
      end
   end

   // Next-state and counter update.
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      gap_d     = gap_q;
      max_d     = max_q;
      tmr_d     = tmr_q;
      timeout_c = (other_c && (max_q == MAX_LAST)) || (!own_c && (gap_q == GAP_LAST));
      case (state_q)
         TLC_GREEN: begin
            gap_d = own_c ? '0 : sat_inc(gap_q, GAP_LAST);
            max_d = other_c ? sat_inc(max_q, MAX_LAST) : max_q;
            if (pre_yield_c || (timeout_c && !pre_hold_c)) begin
               state_d = TLC_YELLOW;
               tmr_d   = '0;
            end
         end
         TLC_YELLOW: begin
            if (tmr_q == YEL_LAST) begin
               state_d = TLC_ALLRED;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + CW'(1);
            end
         end
         TLC_ALLRED: begin
            if (tmr_q != AR_LAST) begin
               tmr_d = tmr_q + CW'(1);
            end else if (pre_take_c || rr_valid_c) begin
               state_d = TLC_GREEN;
               cur_d   = pre_take_c ? pre_target_c : rr_nxt_c;
               gap_d   = '0;
               max_d   = '0;
            end
         end
         default: begin
            state_d = TLC_ALLRED;
            tmr_d   = '0;
         end
      endcase
   end

   // Moore output decode.
   always_comb begin
      phase   = cur_q;
      all_red = (state_q == TLC_ALLRED);
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
         light[i] = red;
         if (PW'(i) == cur_q) begin
            if (state_q == TLC_GREEN)  light[i] = green;
            if (state_q == TLC_YELLOW) light[i] = yellow;
         end
      end
   end

endmodule

// File: tb/tb_tlc_nphase.sv
// Scoreboard bench for tlc_nphase at default parameters.
module tb_tlc_nphase;
   import light_package::*;

   localparam int unsigned N  = 5;
   localparam int unsigned PW = 3;

   typedef struct {
      logic [2*N-1:0] lights;
      logic [PW-1:0]  ph;
      logic           ar;
      string          nm;
   } exp_t;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req;
   logic           preempt;
   logic [PW-1:0]  preempt_phase;
   colors          light [N];
   logic [PW-1:0]  phase;
   logic           all_red;
   logic [2*N-1:0] dut_lights;

   exp_t sb[$];
   event sample_ev;
   int   checks = 0;
   int   errors = 0;

   tlc_nphase dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
`ifdef TLC_PREEMPT_EN
      .preempt       (preempt),
      .preempt_phase (preempt_phase),
`endif
      .light         (light),
      .phase         (phase),
      .all_red       (all_red)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) dut_lights[2*i +: 2] = light[i];
   end

   // Expected outputs: phase ph shows colour c (red means all red).
   task automatic push_exp(input colors c, input int ph, input string nm);
      exp_t e;
      for (int i = 0; i < N; i++)
         e.lights[2*i +: 2] = (i == ph && c != red) ? c : red;
      e.ph = PW'(ph);
      e.ar = (c == red);
      e.nm = nm;
      sb.push_back(e);
   endtask

   // Drive req for one cycle, then expect the given outputs after the edge.
   task automatic step_n(input int n, input logic [N-1:0] r, input colors c,
                         input int ph, input string nm);
      for (int k = 0; k < n; k++) begin
         req = r;
         @(posedge clk);
         #1;
         push_exp(c, ph, nm);
      end
   endtask

   // Monitor: compare one expectation at each sample point.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or sample_ev);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut_lights !== e.lights || phase !== e.ph || all_red !== e.ar) begin
               errors++;
               $display("FAIL %s t=%0t lights=%h want %h phase=%0d want %0d all_red=%0b want %0b",
                        e.nm, $time, dut_lights, e.lights, phase, e.ph, all_red, e.ar);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req = '0;
      preempt = 1'b0;
      preempt_phase = '0;

      step_n(2, 5'b00000, red, 4, "reset_state");
      reset = 1'b0;

      // Single requester gets green on the first edge.
      step_n(3, 5'b00001, green, 0, "t1_green0");
      // Competing demand: 9 green cycles total, 2 yellow, 1 all-red, then phase 2.
      step_n(8, 5'b00101, green, 0, "t2_max_green");
      step_n(2, 5'b00101, yellow, 0, "t2_yellow");
      step_n(1, 5'b00101, red, 0, "t2_allred");
      step_n(1, 5'b00101, green, 2, "t2_green2");
      // Demand drops: 4 idle green cycles, yellow, all-red held.
      step_n(3, 5'b00000, green, 2, "t3_gap_green");
      step_n(2, 5'b00000, yellow, 2, "t3_yellow");
      step_n(4, 5'b00000, red, 2, "t3_allred_hold");
      // Round-robin wrap and self-reselection.
      step_n(1, 5'b01000, green, 3, "t4_green3");
      step_n(3, 5'b00000, green, 3, "t4_gap3");
      step_n(2, 5'b00000, yellow, 3, "t4_yellow3");
      step_n(1, 5'b00000, red, 3, "t4_allred3");
      step_n(1, 5'b00101, green, 0, "t4_rr_wrap");
      step_n(3, 5'b01000, green, 0, "t4_green0");
      step_n(2, 5'b01000, yellow, 0, "t4_yellow0");
      step_n(1, 5'b01000, red, 0, "t4_allred0");
      step_n(1, 5'b01000, green, 3, "t4_rr_to3");
      step_n(3, 5'b00000, green, 3, "t4_gap3b");
      step_n(2, 5'b00000, yellow, 3, "t4_yellow3b");
      step_n(1, 5'b00000, red, 3, "t4_allred3b");
      step_n(1, 5'b01000, green, 3, "t4_rr_self");
      // Asynchronous reset in the middle of yellow.
      step_n(3, 5'b00000, green, 3, "t5_green");
      step_n(1, 5'b00000, yellow, 3, "t5_yellow");
      req = '0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      push_exp(red, 4, "t5_async_reset");
      -> sample_ev;
      step_n(2, 5'b00000, red, 4, "t5_reset_hold");
      reset = 1'b0;
      step_n(2, 5'b00000, red, 4, "t5_idle_hold");
      step_n(1, 5'b00010, green, 1, "t5_green1");
`ifdef TLC_PREEMPT_EN
      preempt = 1'b1;
      preempt_phase = 3'd3;
      step_n(2, 5'b00010, yellow, 1, "pre_yield");
      step_n(1, 5'b00010, red, 1, "pre_allred");
      step_n(1, 5'b00010, green, 3, "pre_green3");
      step_n(12, 5'b00010, green, 3, "pre_hold");
      preempt = 1'b0;
      step_n(1, 5'b00010, yellow, 3, "pre_release");
`endif
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
